// File: rtl/jt6295_pkg.sv
// Shared constants and types for the JT6295 fetch/decode slot scheduler.
package jt6295_pkg;

    // Sample frame lengths in cen ticks for the two rate selects
    localparam int FRAME_TICKS_132   = 132;
    localparam int FRAME_TICKS_165   = 165;

    // Slot lengths: four equal slots at ss=0; ss=1 puts the odd tick in slot 3
    localparam int SLOT_LEN_132      = FRAME_TICKS_132 / 4;                // 33
    localparam int SLOT_LEN_165      = 41;
    localparam int SLOT_LEN_165_LAST = FRAME_TICKS_165 - 3 * SLOT_LEN_165; // 42

    localparam int TICKW = 6;

    // Per-slot fetch state
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } slot_state_t;

    // Index of the final tick of a slot for the given rate
    function automatic logic [TICKW-1:0] slot_last_tick(input logic ss, input logic last_slot);
        if (!ss)
            return TICKW'(SLOT_LEN_132 - 1);
        else if (last_slot)
            return TICKW'(SLOT_LEN_165_LAST - 1);
        else
            return TICKW'(SLOT_LEN_165 - 1);
    endfunction

endpackage

// File: rtl/jt6295_slotcnt.sv
// Tick/slot counter: splits each sample frame into 2**CHW slots of cen ticks.
module jt6295_slotcnt
    import jt6295_pkg::*;
#(
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           ss,
    output logic [CHW-1:0] slot,
    output logic           first_tick,
    output logic           last_tick
);

    logic [TICKW-1:0] tick;
    logic             ss_lat;
    logic             frame_start;
    logic             ss_cur;

    assign first_tick  = (tick == '0);
    assign frame_start = first_tick && (slot == '0);
    // Rate is taken on the frame's first tick and held until the next frame
    assign ss_cur      = frame_start ? ss : ss_lat;
    assign last_tick   = (tick == slot_last_tick(ss_cur, slot == '1));

    // Advance tick within slot, wrap into next slot with no gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick   <= '0;
            slot   <= '0;
            ss_lat <= 1'b0;
        end else if (cen) begin
            if (frame_start)
                ss_lat <= ss;
            if (last_tick) begin
                tick <= '0;
                slot <= slot + CHW'(1);
            end else begin
                tick <= tick + TICKW'(1);
            end
        end
    end

endmodule

// File: rtl/jt6295_sched.sv
// Voice slot scheduler: one ROM fetch and one decoder step per active voice per frame.
module jt6295_sched
    import jt6295_pkg::*;
#(
    parameter int CHW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              ss,
    input  logic [2**CHW-1:0] ch_en,
    output logic              rom_req,
    output logic [CHW-1:0]    rom_ch,
    input  logic              rom_ok,
    output logic [CHW-1:0]    ch,
    output logic              dec_cen,
    output logic              dec_mute,
    output logic              acc_cen4,
    output logic              acc_cen,
    output logic [2**CHW-1:0] underrun,
    input  logic              clr_underrun
);

    localparam int NCH = 2**CHW;

    slot_state_t    st, st_nx;
    logic           first_tick, last_tick;
    logic           slot_end;
    logic           fetch_ok;
    logic           late;
    logic [NCH-1:0] late_mask;

    jt6295_slotcnt #(.CHW(CHW)) u_slotcnt (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .ss         (ss),
        .slot       (ch),
        .first_tick (first_tick),
        .last_tick  (last_tick)
    );

    assign slot_end  = cen & last_tick;
    // rom_ok arriving on the very last tick still counts as an on-time fetch
    assign fetch_ok  = (st == ST_WAIT) & rom_ok;
    assign rom_req   = (st == ST_REQ) | (st == ST_WAIT);
    assign rom_ch    = rom_req ? ch : '0;
    assign acc_cen4  = slot_end;
    assign acc_cen   = slot_end & (ch == '0);
    assign dec_mute  = slot_end & ~((st == ST_DONE) | fetch_ok);
    assign late      = slot_end & rom_req & ~fetch_ok;
    assign late_mask = late ? (NCH'(1) << ch) : '0;

    // Next state: fetch progress, slot start decides fetch, slot end forces idle
    always_comb begin
        st_nx = st;
        case (st)
            ST_REQ:  st_nx = ST_WAIT;
            ST_WAIT: if (rom_ok) st_nx = ST_DONE;
            default: ;
        endcase
        if (cen && first_tick)
            st_nx = ch_en[ch] ? ST_REQ : ST_IDLE;
        if (slot_end)
            st_nx = ST_IDLE;
    end

    // Fetch state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st <= ST_IDLE;
        else
            st <= st_nx;
    end

    // Decoder strobe and sticky late-fetch flags; a same-cycle set beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cen  <= 1'b0;
            underrun <= '0;
        end else begin
            dec_cen  <= fetch_ok;
            underrun <= (clr_underrun ? '0 : underrun) | late_mask;
        end
    end

endmodule
